// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    localparam int LATENCY_MAX = 15;

    // Byte-lane mask for a legal transfer size; zero flags an illegal size.
    function automatic logic [7:0] size_lane_mask(input logic [3:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            SZ_D:    mask = 8'hFF;
            default: mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Byte-lane extract/insert within a 64-bit word plus request checks.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align #(
    parameter int MEM_BYTES = 1024
) (
    input  logic [63:0] i_addr,
    input  logic [3:0]  i_size,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rd_dword,
    output logic [63:0] o_rdata,
    output logic [63:0] o_wr_data,
    output logic [7:0]  o_wr_be,
    output logic        o_error
);
    import dmem_pkg::*;

    localparam logic [64:0] c_MEM_LIMIT = 65'(MEM_BYTES);

    logic [2:0]  w_off;
    logic [5:0]  w_shift;
    logic [7:0]  w_lane_mask;
    logic [63:0] w_data_mask;
    logic        w_size_ok;
    logic        w_misalign;
    logic        w_overflow;

    assign w_off       = i_addr[2:0];
    assign w_shift     = {w_off, 3'b000};
    assign w_lane_mask = size_lane_mask(i_size);
    assign w_size_ok   = (w_lane_mask != 8'h00);
    assign w_misalign  = ((i_addr[3:0] & (i_size - 4'd1)) != 4'd0);
    // 65-bit sum so an address near 2^64 cannot wrap back into range.
    assign w_overflow  = (({1'b0, i_addr} + {61'd0, i_size}) > c_MEM_LIMIT);
    assign o_error     = !w_size_ok || w_misalign || w_overflow;

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign w_data_mask[8*gi +: 8] = {8{w_lane_mask[gi]}};
    end

    assign o_rdata   = o_error ? 64'd0 : ((i_rd_dword >> w_shift) & w_data_mask);
    assign o_wr_be   = o_error ? 8'd0 : (w_lane_mask << w_off);
    assign o_wr_data = i_wdata << w_shift;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency byte-addressed data memory with request/response FSM.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int MEM_BYTES = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_stall
);
    import dmem_pkg::*;

    localparam int         c_AW       = $clog2(MEM_BYTES);
    localparam logic [3:0] c_CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [63:0] r_addr;
    logic [3:0]  r_size;
    logic [63:0] r_wdata;
    logic        r_ready;
    logic        r_rsp_valid;
    logic        r_rsp_error;
    logic [63:0] r_rsp_rdata;
    logic        r_stall;
    logic [7:0]  r_mem [MEM_BYTES];

    logic        w_idle;
    logic        w_write;
    logic [63:0] w_addr;
    logic [3:0]  w_size;
    logic [63:0] w_wdata;
    logic [63:0] w_rd_dword;
    logic [63:0] w_rdata;
    logic [63:0] w_wr_data;
    logic [7:0]  w_wr_be;
    logic        w_error;

    // In IDLE the live request is decoded so LATENCY=1 can respond next cycle.
    assign w_idle  = (r_state == IDLE);
    assign w_write = w_idle ? req_write : r_write;
    assign w_addr  = w_idle ? req_addr  : r_addr;
    assign w_size  = w_idle ? req_size  : r_size;
    assign w_wdata = w_idle ? req_wdata : r_wdata;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rd
        assign w_rd_dword[8*gi +: 8] = r_mem[{w_addr[c_AW-1:3], 3'(gi)}];
    end

    dmem_lane_align #(
        .MEM_BYTES (MEM_BYTES)
    ) u_lane_align (
        .i_addr     (w_addr),
        .i_size     (w_size),
        .i_wdata    (w_wdata),
        .i_rd_dword (w_rd_dword),
        .o_rdata    (w_rdata),
        .o_wr_data  (w_wr_data),
        .o_wr_be    (w_wr_be),
        .o_error    (w_error)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 64'd0;
            r_size      <= 4'd0;
            r_wdata     <= 64'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_stall     <= 1'b0;
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        r_stall <= 1'b1;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= w_error;
                            r_rsp_rdata <= w_write ? 64'd0 : w_rdata;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_error <= w_error;
                        r_rsp_rdata <= w_write ? 64'd0 : w_rdata;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_ready     <= 1'b1;
                    r_stall     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= 64'd0;
                    // Store commits as the response cycle closes; errors leave be=0.
                    if (r_write) begin
                        for (int i = 0; i < 8; i++) begin
                            if (w_wr_be[i]) begin
                                r_mem[{r_addr[c_AW-1:3], 3'(i)}] <= w_wr_data[8*i +: 8];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rsp_rdata;
    assign mem_stall = r_stall;

endmodule
`default_nettype wire
